// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor: CLK-domain receiver for the divided slow clock/tick. Emits TICK per
// rising edge, measures the rise-to-rise period and reports lock/timeout.
// Optional input glitch filter: define SLOW_CLK_MONITOR_DEBOUNCE_EN.
module slow_clk_monitor #(
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned TIMEOUT_CYC = 120000000,
    parameter int unsigned DEB_CYC     = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             SLOW_IN,
    output logic             TICK,
    output logic [CNT_W-1:0] PERIOD,
    output logic             PERIOD_VLD,
    output logic             LOCKED,
    output logic             TIMEOUT_O
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_EDGE = 2'd1;
    localparam logic [1:0] MEASURE   = 2'd2;

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

    // The counter must leave MEASURE before it can wrap.
    if (TIMEOUT_CYC == 0 || 64'(TIMEOUT_CYC) >= (64'd1 << CNT_W) || DEB_CYC == 0) begin : g_bad_param
        $error("slow_clk_monitor: TIMEOUT_CYC must be in 1..2**CNT_W-1 and DEB_CYC >= 1");
    end

    logic             sync1;
    logic             s;
    logic             lev;
    logic             lev_d;
    logic             rise;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] period_nx;
    logic             period_vld_nx;
    logic             locked_nx;
    logic             timeout_nx;
    logic             tick_nx;

    // Two-flop synchroniser for the asynchronous slow input.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= SLOW_IN;
            s     <= sync1;
        end
    end

`ifdef SLOW_CLK_MONITOR_DEBOUNCE_EN
    localparam int unsigned DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic [DEB_W-1:0] deb_cnt;
    logic             filt;

    // Filtered level follows s only after DEB_CYC consecutive differing samples.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            deb_cnt <= '0;
            filt    <= 1'b0;
        end else if (s == filt) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
            deb_cnt <= '0;
            filt    <= s;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    assign lev = filt;
`else
    assign lev = s;
`endif

    // Edge detector on the (optionally filtered) synchronised level.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lev_d <= 1'b0;
        end else begin
            lev_d <= lev;
        end
    end

    assign rise = lev & ~lev_d;

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            PERIOD     <= '0;
            PERIOD_VLD <= 1'b0;
            LOCKED     <= 1'b0;
            TIMEOUT_O  <= 1'b0;
            TICK       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            PERIOD     <= period_nx;
            PERIOD_VLD <= period_vld_nx;
            LOCKED     <= locked_nx;
            TIMEOUT_O  <= timeout_nx;
            TICK       <= tick_nx;
        end
    end

    // Next state and next output values; a rise on the cycle EN falls is dropped.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        period_nx     = PERIOD;
        period_vld_nx = 1'b0;
        locked_nx     = LOCKED;
        timeout_nx    = TIMEOUT_O;
        tick_nx       = 1'b0;

        if (!EN) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            locked_nx  = 1'b0;
            timeout_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = WAIT_EDGE;
                    cnt_nx   = '0;
                end
                WAIT_EDGE: begin
                    tick_nx = rise;
                    if (rise) begin
                        state_nx   = MEASURE;
                        cnt_nx     = CNT_W'(1);
                        timeout_nx = 1'b0;
                    end
                end
                MEASURE: begin
                    tick_nx = rise;
                    if (rise) begin
                        period_nx     = cnt;
                        period_vld_nx = 1'b1;
                        locked_nx     = 1'b1;
                        timeout_nx    = 1'b0;
                        cnt_nx        = CNT_W'(1);
                    end else if (cnt == TIMEOUT_LIM) begin
                        state_nx   = WAIT_EDGE;
                        timeout_nx = 1'b1;
                        locked_nx  = 1'b0;
                        cnt_nx     = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

endmodule
